// File: rtl/opendap_dp_pkg.sv
// Shared constants and payload types for the DPv2 register core and AP tracker.
package opendap_dp_pkg;

    localparam logic [1:0] ACK_OK    = 2'b01;
    localparam logic [1:0] ACK_WAIT  = 2'b10;
    localparam logic [1:0] ACK_FAULT = 2'b00;

    // DP register addresses A[3:2]; read and write functions share an address
    localparam logic [1:0] A_DPIDR_ABORT      = 2'd0;
    localparam logic [1:0] A_CTRL_BANKED      = 2'd1;
    localparam logic [1:0] A_RESEND_SELECT    = 2'd2;
    localparam logic [1:0] A_RDBUFF_TARGETSEL = 2'd3;

    localparam logic [3:0] BANK_CTRL      = 4'd0;
    localparam logic [3:0] BANK_DLCR      = 4'd1;
    localparam logic [3:0] BANK_TARGETID  = 4'd2;
    localparam logic [3:0] BANK_DLPIDR    = 4'd3;
    localparam logic [3:0] BANK_EVENTSTAT = 4'd4;

    localparam logic [31:0] DLCR_VALUE = 32'h0000_0040;

    localparam int unsigned CSYSPWRUPACK_BIT = 31;
    localparam int unsigned CSYSPWRUPREQ_BIT = 30;
    localparam int unsigned CDBGPWRUPACK_BIT = 29;
    localparam int unsigned CDBGPWRUPREQ_BIT = 28;
    localparam int unsigned WDATAERR_BIT     = 7;
    localparam int unsigned READOK_BIT       = 6;
    localparam int unsigned STICKYERR_BIT    = 5;
    localparam int unsigned STICKYORUN_BIT   = 1;
    localparam int unsigned ORUNDETECT_BIT   = 0;

    localparam int unsigned ABORT_DAPABORT   = 0;
    localparam int unsigned ABORT_STKERRCLR  = 2;
    localparam int unsigned ABORT_WDERRCLR   = 3;
    localparam int unsigned ABORT_ORUNERRCLR = 4;

    typedef struct packed {
        logic [7:0] apsel;
        logic [3:0] apbank;
        logic [3:0] dpbank;
    } select_t;

    typedef struct packed {
        logic [7:0]  sel;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } ap_req_t;

endpackage

// File: rtl/opendap_dp_ap_tracker.sv
// Outstanding AP transaction tracker: launch strobes, held bus fields, posted-read
// buffer, READOK and DAPABORT. Out-of-range APs complete internally one cycle later.
module opendap_dp_ap_tracker
    import opendap_dp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        launch,
    input  logic        launch_read,
    input  logic        launch_dummy,
    input  ap_req_t     req,
    input  logic        abort_req,
    input  logic        ap_rdy,
    input  logic [31:0] ap_rdata,
    input  logic        ap_err,
    output logic [7:0]  ap_sel,
    output logic [5:0]  ap_addr,
    output logic [31:0] ap_wdata,
    output logic        ap_wen,
    output logic        ap_ren,
    output logic        ap_abort,
    output logic        busy_c,
    output logic        readok_c,
    output logic        err_c,
    output logic [31:0] rdbuff_c
);

    logic        busy;
    logic        pend_read;
    logic        dummy;
    logic        readok;
    logic [31:0] rdbuff;
    logic        complete;
    logic        err_eff;
    logic [31:0] rdata_eff;

    // Post-completion view so a header in the ap_rdy cycle sees the finished state
    assign complete  = busy & (dummy | ap_rdy);
    assign rdata_eff = dummy ? 32'h0 : ap_rdata;
    assign err_eff   = ~dummy & ap_err;
    assign busy_c    = busy & ~complete;
    assign err_c     = complete & err_eff;
    assign readok_c  = (complete & pend_read) ? ~err_eff : readok;
    assign rdbuff_c  = (complete & pend_read) ? rdata_eff : rdbuff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            pend_read <= 1'b0;
            dummy     <= 1'b0;
            readok    <= 1'b0;
            rdbuff    <= 32'h0;
            ap_sel    <= 8'h0;
            ap_addr   <= 6'h0;
            ap_wdata  <= 32'h0;
            ap_wen    <= 1'b0;
            ap_ren    <= 1'b0;
            ap_abort  <= 1'b0;
        end else begin
            ap_wen   <= launch & ~launch_read & ~launch_dummy;
            ap_ren   <= launch & launch_read & ~launch_dummy;
            ap_abort <= abort_req & busy_c;
            rdbuff   <= rdbuff_c;
            readok   <= readok_c;
            if (launch) begin
                busy      <= 1'b1;
                pend_read <= launch_read;
                dummy     <= launch_dummy;
                ap_sel    <= req.sel;
                ap_addr   <= req.addr;
                ap_wdata  <= req.wdata;
                if (launch_read) begin
                    readok <= 1'b0;
                end
            end else if (complete || (abort_req && busy_c)) begin
                busy  <= 1'b0;
                dummy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/opendap_dp_core.sv
// DPv2 register file and header response decoder in front of the AP transaction tracker.
module opendap_dp_core
    import opendap_dp_pkg::*;
#(
    parameter logic [31:0] DPIDR        = 32'hdeadbeef,
    parameter logic [31:0] TARGETID     = 32'hbaadf00d,
    parameter int unsigned N_APS        = 1,
    parameter bit          EVENTSTAT_EN = 1'b1
) (
    input  logic        swclk,
    input  logic        rst_n,
    input  logic        hdr_valid,
    input  logic [1:0]  hdr_addr,
    input  logic        hdr_r_nw,
    input  logic        hdr_ap_ndp,
    output logic [1:0]  hdr_resp,
    input  logic        host_en,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_protocol_err,
    output logic        cdbgpwrupreq,
    output logic        csyspwrupreq,
    input  logic        cdbgpwrupack,
    input  logic        csyspwrupack,
    input  logic [3:0]  instid,
    input  logic        eventstat,
    output logic [7:0]  ap_sel,
    output logic [5:0]  ap_addr,
    output logic [31:0] ap_wdata,
    output logic        ap_wen,
    output logic        ap_ren,
    output logic        ap_abort,
    input  logic        ap_rdy,
    input  logic [31:0] ap_rdata,
    input  logic        ap_err
);

    localparam logic [8:0] N_APS_W = 9'(N_APS);

    select_t     sel_q;
    logic        orundetect, stickyorun, stickyerr, wdataerr;
    logic        resend_ok;
    logic [31:0] resend_data;
    logic        busy_c, readok_c, err_c;
    logic [31:0] rdbuff_c;
    logic [1:0]  resp_c;
    logic        set_orun;
    logic [31:0] bank_rdata, rdata_c;

    logic dp_rd, dp_wr, ctrl_rd, dpidr_rd, resend_rd, rdbuff_rd;
    logic abort_wr, ctrl_wr, dlcr_wr, select_wr, tsel_wr;
    logic exempt, sticky_any, need_wait, commit;

    assign dp_rd     = ~hdr_ap_ndp & hdr_r_nw;
    assign dp_wr     = ~hdr_ap_ndp & ~hdr_r_nw;
    assign dpidr_rd  = dp_rd & (hdr_addr == A_DPIDR_ABORT);
    assign ctrl_rd   = dp_rd & (hdr_addr == A_CTRL_BANKED) & (sel_q.dpbank == BANK_CTRL);
    assign resend_rd = dp_rd & (hdr_addr == A_RESEND_SELECT);
    assign rdbuff_rd = dp_rd & (hdr_addr == A_RDBUFF_TARGETSEL);
    assign abort_wr  = dp_wr & (hdr_addr == A_DPIDR_ABORT);
    assign ctrl_wr   = dp_wr & (hdr_addr == A_CTRL_BANKED) & (sel_q.dpbank == BANK_CTRL);
    assign dlcr_wr   = dp_wr & (hdr_addr == A_CTRL_BANKED) & (sel_q.dpbank == BANK_DLCR);
    assign select_wr = dp_wr & (hdr_addr == A_RESEND_SELECT);
    assign tsel_wr   = dp_wr & (hdr_addr == A_RDBUFF_TARGETSEL);

    assign exempt     = dpidr_rd | ctrl_rd | abort_wr | tsel_wr;
    assign sticky_any = stickyorun | stickyerr | wdataerr;
    assign need_wait  = busy_c & (hdr_ap_ndp | rdbuff_rd);

    // Response priority: sticky FAULT, then WAIT (or overrun FAULT), then OK
    always_comb begin
        resp_c   = ACK_OK;
        set_orun = 1'b0;
        if (sticky_any && !exempt) begin
            resp_c = ACK_FAULT;
        end else if (need_wait) begin
            if (orundetect) begin
                resp_c   = ACK_FAULT;
                set_orun = hdr_valid;
            end else begin
                resp_c = ACK_WAIT;
            end
        end
    end

    assign hdr_resp = hdr_valid ? resp_c : ACK_FAULT;
    assign commit   = host_en & hdr_valid & (resp_c == ACK_OK);

    always_comb begin
        bank_rdata = 32'h0;
        case (sel_q.dpbank)
            BANK_CTRL: begin
                bank_rdata[CSYSPWRUPACK_BIT] = csyspwrupack;
                bank_rdata[CSYSPWRUPREQ_BIT] = csyspwrupreq;
                bank_rdata[CDBGPWRUPACK_BIT] = cdbgpwrupack;
                bank_rdata[CDBGPWRUPREQ_BIT] = cdbgpwrupreq;
                bank_rdata[WDATAERR_BIT]     = wdataerr;
                bank_rdata[READOK_BIT]       = readok_c;
                bank_rdata[STICKYERR_BIT]    = stickyerr;
                bank_rdata[STICKYORUN_BIT]   = stickyorun;
                bank_rdata[ORUNDETECT_BIT]   = orundetect;
            end
            BANK_DLCR:      bank_rdata = DLCR_VALUE;
            BANK_TARGETID:  bank_rdata = TARGETID;
            BANK_DLPIDR:    bank_rdata = {instid, 24'h0, 4'h1};
            BANK_EVENTSTAT: bank_rdata[0] = EVENTSTAT_EN & eventstat;
            default:        bank_rdata = 32'h0;
        endcase
    end

    always_comb begin
        rdata_c = 32'h0;
        if (hdr_ap_ndp) begin
            rdata_c = rdbuff_c;
        end else begin
            case (hdr_addr)
                A_DPIDR_ABORT:      rdata_c = DPIDR;
                A_CTRL_BANKED:      rdata_c = bank_rdata;
                A_RESEND_SELECT:    rdata_c = resend_ok ? resend_data : 32'h0;
                A_RDBUFF_TARGETSEL: rdata_c = rdbuff_c;
                default:            rdata_c = 32'h0;
            endcase
        end
    end

    assign host_rdata = hdr_valid ? rdata_c : 32'h0;

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q             <= '0;
            orundetect        <= 1'b0;
            stickyorun        <= 1'b0;
            stickyerr         <= 1'b0;
            wdataerr          <= 1'b0;
            cdbgpwrupreq      <= 1'b0;
            csyspwrupreq      <= 1'b0;
            resend_ok         <= 1'b0;
            resend_data       <= 32'h0;
            host_protocol_err <= 1'b0;
        end else begin
            host_protocol_err <= 1'b0;
            if (commit) begin
                if (abort_wr) begin
                    if (host_wdata[ABORT_STKERRCLR])  stickyerr  <= 1'b0;
                    if (host_wdata[ABORT_WDERRCLR])   wdataerr   <= 1'b0;
                    if (host_wdata[ABORT_ORUNERRCLR]) stickyorun <= 1'b0;
                end
                if (ctrl_wr) begin
                    csyspwrupreq <= host_wdata[CSYSPWRUPREQ_BIT];
                    cdbgpwrupreq <= host_wdata[CDBGPWRUPREQ_BIT];
                    orundetect   <= host_wdata[ORUNDETECT_BIT];
                end
                if (select_wr) begin
                    sel_q <= '{apsel: host_wdata[31:24], apbank: host_wdata[7:4],
                               dpbank: host_wdata[3:0]};
                end
                // RESEND itself keeps the saved data so it may be repeated
                if (hdr_ap_ndp || rdbuff_rd) begin
                    resend_ok   <= 1'b1;
                    resend_data <= rdata_c;
                end else if (!resend_rd) begin
                    resend_ok <= 1'b0;
                end
                host_protocol_err <= (resend_rd & ~resend_ok) | (dlcr_wr & (|host_wdata[9:8]));
            end
            if (set_orun) stickyorun <= 1'b1;
            if (err_c)    stickyerr  <= 1'b1;
        end
    end

    opendap_dp_ap_tracker u_tracker (
        .clk          (swclk),
        .rst_n        (rst_n),
        .launch       (commit & hdr_ap_ndp),
        .launch_read  (hdr_r_nw),
        .launch_dummy ({1'b0, sel_q.apsel} >= N_APS_W),
        .req          ('{sel: sel_q.apsel, addr: {sel_q.apbank, hdr_addr}, wdata: host_wdata}),
        .abort_req    (commit & abort_wr & host_wdata[ABORT_DAPABORT]),
        .ap_rdy       (ap_rdy),
        .ap_rdata     (ap_rdata),
        .ap_err       (ap_err),
        .ap_sel       (ap_sel),
        .ap_addr      (ap_addr),
        .ap_wdata     (ap_wdata),
        .ap_wen       (ap_wen),
        .ap_ren       (ap_ren),
        .ap_abort     (ap_abort),
        .busy_c       (busy_c),
        .readok_c     (readok_c),
        .err_c        (err_c),
        .rdbuff_c     (rdbuff_c)
    );

endmodule

// File: doc/opendap_dp_core.md
Name: opendap_dp_core

Overview:
- Parametrised DPv2 register core and AP transaction engine.
- Sits between the SW-DP serial comms unit and the AP bus.
- Generalises the SW-DP register file:
  - decodes header responses OK/WAIT/FAULT itself;
  - tracks an outstanding AP transaction, with posted AP reads captured into a real RDBUFF register;
  - implements DAPABORT, READOK and ORUNDETECT;
  - range-checks APSEL against a configurable AP count.

Parameters:
- DPIDR, 32'hdeadbeef, value returned by DPIDR reads.
- TARGETID, 32'hbaadf00d, TARGETID register value.
- N_APS, 1, number of implemented APs (1..256); APSEL >= N_APS selects a RAZ/WI dummy.
- EVENTSTAT_EN, 1, 0 makes EVENTSTAT read as 0.

Ports:
- swclk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hdr_valid  in  1  header decoded; hdr_* fields valid
- hdr_addr  in  2  A[3:2]
- hdr_r_nw  in  1  1 = read
- hdr_ap_ndp  in  1  1 = AP access
- hdr_resp  out  2  combinational: 2'b01 OK, 2'b10 WAIT, 2'b00 FAULT
- host_en  in  1  data phase commit; only pulsed after an OK response
- host_wdata  in  32  write data, valid with host_en
- host_rdata  out  32  read data for the current header, valid while hdr_valid
- host_protocol_err  out  1  bad TURNROUND write or bad RESEND read
- cdbgpwrupreq / csyspwrupreq  out  1  power requests
- cdbgpwrupack / csyspwrupack  in  1  power acks
- instid  in  4  TINSTANCE
- eventstat  in  1  event status
- ap_sel  out  8  registered APSEL
- ap_addr  out  6  {APBANKSEL, A[3:2]}
- ap_wdata  out  32  registered write data
- ap_wen / ap_ren  out  1  single-cycle launch strobes
- ap_abort  out  1  single-cycle abort strobe
- ap_rdy  in  1  completion, one cycle
- ap_rdata  in  32  read data, valid with ap_rdy
- ap_err  in  1  error, valid with ap_rdy

Behaviour:
- Reset: all outputs 0; SELECT = 0, CTRL/STAT = 0, rdbuff = 0, busy = 0, resend_ok = 0.
- State: busy flag plus pending type (read/write). An AP transaction is launched on host_en for an AP access with resp OK:
  - ap_wen or ap_ren pulses for 1 cycle after host_en;
  - ap_sel, ap_addr and ap_wdata are held stable until ap_rdy.
- busy clears on the ap_rdy cycle.
- APSEL >= N_APS:
  - no strobe is issued;
  - the transaction completes in 1 cycle as if ap_rdy=1, ap_rdata=0, ap_err=0.
- Read completion: rdbuff <= ap_rdata, READOK <= !ap_err. An ap_err completion sets STICKYERR, for reads and writes.
- READOK clears on the launch of any AP read.
- Posted reads: an AP read returns the current rdbuff, i.e. the previous AP read result. DP RDBUFF (A=2'b11) read returns rdbuff and launches nothing.
- hdr_resp priority:
  1. FAULT: any sticky flag (STICKYORUN, STICKYERR, WDATAERR) is set, unless the access is a DPIDR read, CTRL/STAT read, ABORT write or TARGETSEL write.
  2. WAIT: busy, and the access is an AP access or an RDBUFF read. With ORUNDETECT=1 this sets STICKYORUN and returns FAULT instead.
  3. Otherwise OK.
- ap_rdy in the same cycle as hdr_valid: decode uses the post-completion state, so busy is treated as already clear.
- ABORT write:
  - bit0 DAPABORT with busy: pulse ap_abort, clear busy, leave rdbuff unchanged.
  - bits 2/3/4 clear STICKYERR/WDATAERR/STICKYORUN.
  - An ABORT write is accepted even while busy.
- CTRL/STAT (bank 0) write: CSYSPWRUPREQ[30], CDBGPWRUPREQ[28], ORUNDETECT[0]; all other bits RAZ/WI.
- Read map by DPBANKSEL, all returned values:
  - A=00: DPIDR.
  - A=01, bank 0: CTRL/STAT {acks, reqs, WDATAERR[7], READOK[6], STICKYERR[5], STICKYORUN[1], ORUNDETECT[0]}.
  - A=01, banks 1–4: DLCR = 0x40; TARGETID; DLPIDR = {instid, 24'h0, 4'h1}; EVENTSTAT.
  - A=01, other banks: 0.
- RESEND read (A=10): returns the last returned AP/RDBUFF data.
  - resend_ok is set by an AP read or RDBUFF read, and cleared by any other committed access.
  - RESEND with !resend_ok raises host_protocol_err and returns 0.
- DLCR write with TURNROUND != 0: host_protocol_err.
- Reset mid-transaction: busy drops immediately; no ap_abort is issued; the AP is reset by the same rst_n.

Decomposition:
- Shared package opendap_dp_pkg holds:
  - response codes ACK_OK/ACK_WAIT/ACK_FAULT;
  - DP address/bank constants;
  - CTRL/STAT and ABORT bit indices.
- One sub-module opendap_dp_ap_tracker: busy/pending state, launch strobes, rdbuff, READOK, abort handling.

Test Plan:
- Two AP reads to AP0 addr 0 with ap_rdata 0x11111111 then 0x22222222 -> first returns 0 (reset rdbuff), second returns 0x11111111, RDBUFF returns 0x22222222.
- AP write while ap_rdy is held low, then AP read -> WAIT; with ORUNDETECT=1 -> FAULT and STICKYORUN=1 in CTRL/STAT; ABORT 0x10 clears it.
- ap_rdy with ap_err=1 -> STICKYERR=1; next AP read FAULT; DPIDR read OK returns DPIDR; ABORT 0x04 restores OK.
- Pending AP read, then ABORT 0x01 -> ap_abort pulses 1 cycle, next AP access OK, READOK=0.
- SELECT APSEL=N_APS, AP write then AP read, RDBUFF -> no ap_wen/ap_ren pulses, RDBUFF=0, no sticky flags.
- RESEND after a CTRL/STAT read -> host_protocol_err=1; RESEND after an RDBUFF read -> same data repeated.
